// File: rtl/sys_rst_seq.sv
// sys_rst_seq: merges clock-lock, push-button and FX3 resets into one
// stretched, synchronously released SYS_RST_N. Watchdog: RST_SEQ_WDOG_EN.
module sys_rst_seq #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STRETCH_CYCLES  = 64,
  parameter int unsigned WDOG_CYCLES     = 1048576
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       BOARD_RST_SW,
  input  logic       SL_RST_N,
  input  logic       WDOG_KICK,
  input  logic       RST_CAUSE_CLR,
  output logic       SYS_RST_N,
  output logic       RST_DONE,
  output logic [2:0] RST_CAUSE
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StW = $clog2(STRETCH_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sw_sync_q, sw_sync_d;
  logic [SYNC_STAGES-1:0] sl_sync_q, sl_sync_d;
  logic                   sw_s, sl_s;

  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           sw_db_q, sw_db_d;

  logic [StW-1:0] st_cnt_q, st_cnt_d;

  logic       sys_rst_n_q, sys_rst_n_d;
  logic       rst_done_q, rst_done_d;
  logic [2:0] cause_q, cause_d;

  logic wdog_fire;
  logic req;

  // Shift the asynchronous inputs through the synchronizer chains
  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], BOARD_RST_SW};
    sl_sync_d = {sl_sync_q[SYNC_STAGES-2:0], SL_RST_N};
  end

  assign sw_s = sw_sync_q[SYNC_STAGES-1];
  assign sl_s = sl_sync_q[SYNC_STAGES-1];

  // Debounce: accept sw_s only after it differs from sw_db long enough
  always_comb begin
    db_cnt_d = '0;
    sw_db_d  = sw_db_q;
    if (sw_s != sw_db_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        sw_db_d = sw_s;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

`ifdef RST_SEQ_WDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

  assign wdog_fire = (state_q == RUN) &&
                     (wd_cnt_q == WdW'(WDOG_CYCLES - 1));

  // Watchdog counts idle RUN cycles; kick, fire or leaving RUN clear it
  always_comb begin
    wd_cnt_d = wd_cnt_q + WdW'(1);
    if ((state_q != RUN) || WDOG_KICK || wdog_fire) begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_wdog;

  assign wdog_fire   = 1'b0;
  assign unused_wdog = WDOG_KICK ^ (WDOG_CYCLES == 0);
`endif

  assign req = sw_db_q | ~sl_s | wdog_fire;

  // State register
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stretch counter; any request restarts the stretch
  always_comb begin
    state_d  = state_q;
    st_cnt_d = '0;
    unique case (state_q)
      HOLD: begin
        if (!req) state_d = STRETCH;
      end
      STRETCH: begin
        if (req) begin
          state_d = HOLD;
        end else if (st_cnt_q == StW'(STRETCH_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          st_cnt_d = st_cnt_q + StW'(1);
        end
      end
      RUN: begin
        if (req) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
  end

  // Outputs follow next_state so SYS_RST_N moves on the RUN transition edge
  always_comb begin
    sys_rst_n_d = (state_d == RUN);
    rst_done_d  = (state_d == RUN) && (state_q != RUN);
    cause_d     = RST_CAUSE_CLR ? 3'b000 : cause_q;
    if (state_q == RUN) begin
      cause_d = cause_d | {wdog_fire, ~sl_s, sw_db_q};
    end
  end

  // Datapath registers; synchronizers reset to their inactive levels
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_sync_q   <= '0;
      sl_sync_q   <= '1;
      db_cnt_q    <= '0;
      sw_db_q     <= 1'b0;
      st_cnt_q    <= '0;
      sys_rst_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
      cause_q     <= 3'b000;
    end else begin
      sw_sync_q   <= sw_sync_d;
      sl_sync_q   <= sl_sync_d;
      db_cnt_q    <= db_cnt_d;
      sw_db_q     <= sw_db_d;
      st_cnt_q    <= st_cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
      rst_done_q  <= rst_done_d;
      cause_q     <= cause_d;
    end
  end

  assign SYS_RST_N = sys_rst_n_q;
  assign RST_DONE  = rst_done_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// tb_sys_rst_seq: directed plus randomized bench for sys_rst_seq against a
// rule-level model. Define RST_SEQ_WDOG_EN to cover the watchdog.
module tb_sys_rst_seq;

  localparam int SS = 2;
  localparam int DB = 16;
  localparam int ST = 64;
  localparam int WD = 1000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sw    = 1'b0;
  logic       sl    = 1'b1;
  logic       kick  = 1'b0;
  logic       clr   = 1'b0;
  logic       sys_rst_n;
  logic       rst_done;
  logic [2:0] cause;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sys_rst_seq #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .STRETCH_CYCLES (ST),
    .WDOG_CYCLES    (WD)
  ) dut (
    .SYS_CLK      (clk),
    .RST_N        (rst_n),
    .BOARD_RST_SW (sw),
    .SL_RST_N     (sl),
    .WDOG_KICK    (kick),
    .RST_CAUSE_CLR(clr),
    .SYS_RST_N    (sys_rst_n),
    .RST_DONE     (rst_done),
    .RST_CAUSE    (cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: output is high once req has been quiet for more
  // than ST consecutive edges; causes latch only while output is high.
  logic [SS-1:0] m_sw_p, m_sl_p;
  logic          m_db, m_run, m_done;
  logic [2:0]    m_cause;
  int            m_db_run, m_quiet, m_wd;

  always @(posedge clk or negedge rst_n) begin : model
    logic sw_s, sl_s, fire, req, nrun;
    if (!rst_n) begin
      m_sw_p   = '0;
      m_sl_p   = '1;
      m_db     = 1'b0;
      m_run    = 1'b0;
      m_done   = 1'b0;
      m_cause  = 3'b000;
      m_db_run = 0;
      m_quiet  = 0;
      m_wd     = 0;
    end else begin
      sw_s = m_sw_p[SS-1];
      sl_s = m_sl_p[SS-1];
`ifdef RST_SEQ_WDOG_EN
      fire = m_run && (m_wd == WD - 1);
`else
      fire = 1'b0;
`endif
      req = m_db | ~sl_s | fire;
      if (clr) m_cause = 3'b000;
      if (m_run) m_cause = m_cause | {fire, ~sl_s, m_db};
      m_quiet = req ? 0 : m_quiet + 1;
      nrun    = (m_quiet > ST);
      m_done  = nrun && !m_run;
      m_wd    = (m_run && !kick && !fire) ? m_wd + 1 : 0;
      m_run   = nrun;
      if (sw_s != m_db) begin
        m_db_run++;
        if (m_db_run == DB) begin
          m_db     = sw_s;
          m_db_run = 0;
        end
      end else begin
        m_db_run = 0;
      end
      m_sw_p = {m_sw_p[SS-2:0], sw};
      m_sl_p = {m_sl_p[SS-2:0], sl};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sys_rst_n", 32'(sys_rst_n), 32'(m_run));
      check("rst_done", 32'(rst_done), 32'(m_done));
      check("rst_cause", 32'(cause), 32'(m_cause));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_lvl(input logic lvl, input int bound,
                          output int lat);
    bit hit;
    hit = 1'b0;
    lat = bound + 1;
    for (int i = 1; i <= bound; i++) begin
      if (!hit) begin
        @(negedge clk);
        if (sys_rst_n === lvl) begin
          hit = 1'b1;
          lat = i;
        end
      end
    end
    #1;
  endtask

  task automatic cyc_rand(input int n);
    for (int i = 0; i < n; i++) begin
      kick = ($urandom_range(0, 199) == 0);
      step(1);
    end
    kick = 1'b0;
  endtask

  initial begin
    int lat;
    int fell;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_out", 32'(sys_rst_n), 32'd0);
    check("rst_done0", 32'(rst_done), 32'd0);
    check("rst_cause0", 32'(cause), 32'd0);
    #1 rst_n = 1'b1;

    wait_lvl(1'b1, 200, lat);
    check("pwrup_lat", 32'(lat), 32'd65);
    check("pwrup_done", 32'(rst_done), 32'd1);
    check("pwrup_cause", 32'(cause), 32'd0);

    sw = 1'b1;
    step(10);
    sw = 1'b0;
    step(40);
    check("sw_short", 32'(sys_rst_n), 32'd1);

    sw   = 1'b1;
    fell = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fell == 0 && sys_rst_n === 1'b0) fell = i;
    end
    #1 sw = 1'b0;
    check("sw_fall", 32'(fell), 32'd19);
    check("sw_cause", 32'(cause), 32'd1);
    wait_lvl(1'b1, 200, lat);
    check("sw_rise", 32'(lat), 32'd83);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr1", 32'(cause), 32'd0);

    sl = 1'b0;
    step(1);
    sl = 1'b1;
    wait_lvl(1'b0, 20, lat);
    check("sl_fall", 32'(lat + 1), 32'd3);
    check("sl_cause", 32'(cause), 32'd2);
    wait_lvl(1'b1, 200, lat);
    check("sl_rise", 32'(lat), 32'd65);

    sl = 1'b0;
    step(1);
    sl = 1'b1;
    step(25);
    sw = 1'b1;
    step(30);
    sw = 1'b0;
    wait_lvl(1'b1, 300, lat);
    check("restretch", 32'(lat), 32'd83);
    check("restretch_cause", 32'(cause), 32'd2);

    sw = 1'b1;
    step(16);
    sl = 1'b0;
    step(1);
    sl = 1'b1;
    step(23);
    sw = 1'b0;
    check("simul_cause", 32'(cause), 32'd3);
    wait_lvl(1'b1, 200, lat);
    check("simul_rise", 32'(lat), 32'd83);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr3", 32'(cause), 32'd0);

    sl = 1'b0;
    step(1);
    sl = 1'b1;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("set_wins", 32'(cause), 32'd2);
    wait_lvl(1'b1, 200, lat);
    check("set_wins_rise", 32'(lat), 32'd65);

    clr = 1'b1;
    step(1);
    clr  = 1'b0;
    fell = 0;
    for (int c = 0; c < 10000; c++) begin
      kick = (c % 500 == 0);
      @(negedge clk);
      if (sys_rst_n !== 1'b1) fell++;
      #1;
    end
    kick = 1'b1;
    step(1);
    kick = 1'b0;
    check("wdog_hold", 32'(fell), 32'd0);
    wait_lvl(1'b0, 1200, lat);
`ifdef RST_SEQ_WDOG_EN
    check("wdog_lat", 32'(lat), 32'd1000);
    check("wdog_cause", 32'(cause), 32'd4);
    wait_lvl(1'b1, 200, lat);
    check("wdog_rise", 32'(lat), 32'd65);
`else
    check("wdog_lat", 32'(lat), 32'd1201);
    check("wdog_cause", 32'(cause), 32'd0);
`endif

    for (int s = 0; s < 150; s++) begin
      int act;
      act = int'($urandom_range(0, 5));
      if (act == 0) begin
        cyc_rand(int'($urandom_range(1, 100)));
      end else if (act == 1) begin
        sw = 1'b1;
        cyc_rand(int'($urandom_range(1, 40)));
        sw = 1'b0;
        cyc_rand(int'($urandom_range(1, 30)));
      end else if (act == 2) begin
        sl = 1'b0;
        cyc_rand(int'($urandom_range(1, 3)));
        sl = 1'b1;
        cyc_rand(int'($urandom_range(1, 30)));
      end else if (act == 3) begin
        clr = 1'b1;
        cyc_rand(1);
        clr = 1'b0;
      end else if (act == 4) begin
        #($urandom_range(0, 3));
        rst_n = 1'b0;
        step(int'($urandom_range(1, 5)));
        rst_n = 1'b1;
        cyc_rand(int'($urandom_range(1, 80)));
      end else begin
        for (int i = 0; i < 20; i++) begin
          sw = 1'($urandom_range(0, 1));
          cyc_rand(1);
        end
        sw = 1'b0;
      end
    end

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_rst_seq.md
Name: sys_rst_seq

Overview:
- System reset sequencer between the clock manager and the dut.
- Merges three reset sources into one clean, stretched, synchronously-deasserted SYS_RST_N for the SYS_CLK domain:
  - clock-manager lock (RST_N),
  - board push-button (BOARD_RST_SW),
  - FX3 reset (SL_RST_N).
- Records which source caused the last reset, in a sticky status register.

Parameters:
SYNC_STAGES, 2, synchronizer depth for BOARD_RST_SW and SL_RST_N (>=2)
DEBOUNCE_CYCLES, 16, cycles BOARD_RST_SW must be stable before its debounced value changes
STRETCH_CYCLES, 64, minimum SYS_RST_N low time after all causes clear
WDOG_CYCLES, 1048576, watchdog timeout in SYS_CLK cycles (optional feature only)

Ports:
SYS_CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset (driven by SYS_CLK_STABLE)
BOARD_RST_SW  input  1  asynchronous active-high push-button
SL_RST_N  input  1  asynchronous active-low FX3 reset
WDOG_KICK  input  1  heartbeat from dut; active-high
RST_CAUSE_CLR  input  1  one-cycle pulse, clears RST_CAUSE
SYS_RST_N  output  1  sequenced reset to dut; registered
RST_DONE  output  1  one-cycle pulse when SYS_RST_N rises
RST_CAUSE  output  3  sticky {wdog, sl, sw}

Behaviour:

RST_N low (async):
- FSM goes to HOLD.
- SYS_RST_N=0, RST_DONE=0, RST_CAUSE=000.
- All counters are 0.
- Synchronizers reset to the inactive values (sw=0, sl=1).

Synchronizing and debounce:
- BOARD_RST_SW and SL_RST_N each pass through SYNC_STAGES flops, giving sw_s and sl_s.
- Debounce: a counter clears on any change of sw_s and increments while sw_s differs from sw_db.
  - sw_db takes the value of sw_s on the edge where the count reaches DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- sl_s is not debounced. A single synchronized low cycle is a request.

Request:
- req = sw_db | ~sl_s | wdog_fire (combinational).

FSM states:
- HOLD: if !req, go to STRETCH and clear cnt.
- STRETCH:
  - If req, go back to HOLD.
  - Else cnt++.
  - On cnt==STRETCH_CYCLES-1, go to RUN.
- RUN: if req, go to HOLD.

Outputs:
- SYS_RST_N <= (next_state==RUN), so it changes on the same edge the FSM enters or leaves RUN. It is glitch-free.
- RST_DONE <= (next_state==RUN && state!=RUN).

Latency:
- Power-up with no causes: SYS_RST_N rises at edge 1+STRETCH_CYCLES after RST_N deasserts.
- SL_RST_N falling in RUN: SYS_RST_N falls at edge SYNC_STAGES+1.
- Button press in RUN: SYS_RST_N falls at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.

RST_CAUSE:
- A bit is set in any cycle where state==RUN and that bit's request term is active.
- Bits are set only, never auto-cleared.
- RST_CAUSE_CLR zeroes all bits. If set and clear occur in the same cycle, set wins.
- Causes arriving in HOLD or STRETCH are not recorded; the reset is already in progress.

Boundary conditions:
- Simultaneous causes set all matching bits.
- A request during STRETCH restarts the full stretch.
- RST_N low mid-stretch or mid-debounce aborts everything immediately.

Optional Feature:
Macro: RST_SEQ_WDOG_EN.

With RST_SEQ_WDOG_EN defined:
- A watchdog counter runs only in RUN.
- It clears on WDOG_KICK=1 and whenever state!=RUN.
- On reaching WDOG_CYCLES-1 it asserts wdog_fire for one cycle. This sends the FSM to HOLD and sets RST_CAUSE[2].

Without RST_SEQ_WDOG_EN:
- No watchdog logic. wdog_fire=0, RST_CAUSE[2]=0.
- WDOG_KICK stays in the port list but is ignored.

Test Plan:
Parameters for all cases: SYNC_STAGES=2, DEBOUNCE_CYCLES=16, STRETCH_CYCLES=64, WDOG_CYCLES=1000.

1. RST_N low 10 cycles, BOARD_RST_SW=0, SL_RST_N=1, then release -> SYS_RST_N rises at edge 65; RST_DONE pulses 1 cycle at edge 65; RST_CAUSE=000.
2. In RUN, BOARD_RST_SW high for 10 cycles -> no reset. Then BOARD_RST_SW high for 40 cycles -> SYS_RST_N falls at edge 19 after the rise; RST_CAUSE=001; SYS_RST_N rises 83 edges after release.
3. In RUN, SL_RST_N low for 1 cycle -> SYS_RST_N falls at edge 3; RST_CAUSE=010; SYS_RST_N high again 65 edges after sl_s returns high.
4. BOARD_RST_SW held (debounced) at STRETCH cnt=40 -> back to HOLD; after release a full 64-cycle stretch occurs; RST_CAUSE unchanged.
5. RST_CAUSE=011 plus an RST_CAUSE_CLR pulse -> 000. A cause set in the same cycle as RST_CAUSE_CLR -> that bit reads 1.
6. With RST_SEQ_WDOG_EN:
   - Kick every 500 cycles for 10000 cycles -> no reset.
   - Stop kicking -> SYS_RST_N falls 1000 cycles after the last kick; RST_CAUSE=100.
   - Without the macro, same stimulus -> no reset.
